// File: rtl/even_odd_stream_classifier.sv
// Streaming even/odd classifier with a 1-entry registered output stage,
// saturating even/odd tallies and a same-parity run-length counter.
// Latency 1 cycle; in_ready = !out_valid || out_ready, so output holds under backpressure.
// Optional feature macro: EVEN_ODD_PARITY_EN adds out_parity (^out_data, registered).
module even_odd_stream_classifier #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_even,
  output logic [CNT_WIDTH-1:0] even_cnt,
  output logic [CNT_WIDTH-1:0] odd_cnt,
`ifdef EVEN_ODD_PARITY_EN
  output logic [CNT_WIDTH-1:0] run_len,
  output logic                 out_parity
`else
  output logic [CNT_WIDTH-1:0] run_len
`endif
);

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_even_q, out_even_d;
  logic [CNT_WIDTH-1:0] even_cnt_q, even_cnt_d;
  logic [CNT_WIDTH-1:0] odd_cnt_q, odd_cnt_d;
  logic [CNT_WIDTH-1:0] run_len_q, run_len_d;
  logic                 last_par_q, last_par_d;
  logic                 have_last_q, have_last_d;
`ifdef EVEN_ODD_PARITY_EN
  logic                 out_parity_q, out_parity_d;
`endif

  logic                 accept;
  logic                 parity;
  logic [CNT_WIDTH-1:0] even_base, odd_base, run_base;
  logic                 have_last_base;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
    return (x == '1) ? x : x + CNT_WIDTH'(1);
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign parity   = in_data[0];

  // Output stage next state: load on accept, drain when consumer takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_even_d  = out_even_q;
`ifdef EVEN_ODD_PARITY_EN
    out_parity_d = out_parity_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_even_d  = ~in_data[0];
`ifdef EVEN_ODD_PARITY_EN
      out_parity_d = ^in_data;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Statistics next state: clear is applied first so a same-cycle sample counts from zero.
  always_comb begin
    even_base      = clear ? '0 : even_cnt_q;
    odd_base       = clear ? '0 : odd_cnt_q;
    run_base       = clear ? '0 : run_len_q;
    have_last_base = clear ? 1'b0 : have_last_q;
    even_cnt_d     = even_base;
    odd_cnt_d      = odd_base;
    run_len_d      = run_base;
    have_last_d    = have_last_base;
    last_par_d     = last_par_q;
    if (accept) begin
      if (parity) odd_cnt_d  = sat_inc(odd_base);
      else        even_cnt_d = sat_inc(even_base);
      // last_par is only meaningful while have_last is set, so clear leaves it alone.
      if (have_last_base && (parity == last_par_q)) run_len_d = sat_inc(run_base);
      else                                          run_len_d = CNT_WIDTH'(1);
      last_par_d  = parity;
      have_last_d = 1'b1;
    end
  end

  // State registers; async reset drops any in-flight output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_even_q  <= 1'b0;
      even_cnt_q  <= '0;
      odd_cnt_q   <= '0;
      run_len_q   <= '0;
      last_par_q  <= 1'b0;
      have_last_q <= 1'b0;
`ifdef EVEN_ODD_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_even_q  <= out_even_d;
      even_cnt_q  <= even_cnt_d;
      odd_cnt_q   <= odd_cnt_d;
      run_len_q   <= run_len_d;
      last_par_q  <= last_par_d;
      have_last_q <= have_last_d;
`ifdef EVEN_ODD_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_even  = out_even_q;
  assign even_cnt  = even_cnt_q;
  assign odd_cnt   = odd_cnt_q;
  assign run_len   = run_len_q;
`ifdef EVEN_ODD_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_even_odd_stream_classifier.sv
// Bench for even_odd_stream_classifier: a WIDTH=4 instance checked through a
// scoreboard of expected {even,data} pairs, plus a WIDTH=8/CNT_WIDTH=2 instance
// used for counter saturation and the optional parity output.
module tb_even_odd_stream_classifier;

  logic clk;
  logic rst;
  logic clear;

  // WIDTH=4, CNT_WIDTH=16 instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_even;
  logic [3:0]  a_in_data, a_out_data;
  logic [15:0] a_even_cnt, a_odd_cnt, a_run_len;
  // WIDTH=8, CNT_WIDTH=2 instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_even;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_even_cnt, b_odd_cnt, b_run_len;
`ifdef EVEN_ODD_PARITY_EN
  logic        a_out_parity, b_out_parity;
`endif

  int errors = 0;
  int checks = 0;
  logic [4:0] sb[$];  // {expected out_even, expected out_data}

  even_odd_stream_classifier #(.WIDTH(4), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_even(a_out_even), .even_cnt(a_even_cnt), .odd_cnt(a_odd_cnt),
`ifdef EVEN_ODD_PARITY_EN
    .run_len(a_run_len), .out_parity(a_out_parity)
`else
    .run_len(a_run_len)
`endif
  );

  even_odd_stream_classifier #(.WIDTH(8), .CNT_WIDTH(2)) u_b (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_even(b_out_even), .even_cnt(b_even_cnt), .odd_cnt(b_odd_cnt),
`ifdef EVEN_ODD_PARITY_EN
    .run_len(b_run_len), .out_parity(b_out_parity)
`else
    .run_len(b_run_len)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [3:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    sb.push_back({~d[0], d});
  endtask

  // Scoreboard consumer: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", {28'd0, a_out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [4:0] e;
        e = sb.pop_front();
        chk("sb_out_data", {28'd0, a_out_data}, {28'd0, e[3:0]});
        chk("sb_out_even", {31'd0, a_out_even}, {31'd0, e[4]});
      end
    end
  end

  initial begin
    rst = 1'b0; clear = 1'b0;
    a_in_valid = 1'b1; a_in_data = 4'd5; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 8'd7; b_out_ready = 1'b1;
    #2 rst = 1'b1;
    tick(); tick();
    // Reset holds everything at zero even with in_valid high.
    chk("rst_a_out_valid", {31'd0, a_out_valid}, 0);
    chk("rst_a_out_data",  {28'd0, a_out_data}, 0);
    chk("rst_a_out_even",  {31'd0, a_out_even}, 0);
    chk("rst_a_even_cnt",  {16'd0, a_even_cnt}, 0);
    chk("rst_a_odd_cnt",   {16'd0, a_odd_cnt}, 0);
    chk("rst_a_run_len",   {16'd0, a_run_len}, 0);
    chk("rst_a_in_ready",  {31'd0, a_in_ready}, 1);
    chk("rst_b_out_valid", {31'd0, b_out_valid}, 0);
    chk("rst_b_in_ready",  {31'd0, b_in_ready}, 1);
`ifdef EVEN_ODD_PARITY_EN
    chk("rst_a_out_parity", {31'd0, a_out_parity}, 0);
`endif
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Full-throughput stream 6,3,14,10,11,7.
    drive_a(4'd6);  tick();
    drive_a(4'd3);  tick();
    drive_a(4'd14); tick();
    drive_a(4'd10); tick();
    drive_a(4'd11); tick();
    drive_a(4'd7);  tick();
    chk("stream_even_cnt", {16'd0, a_even_cnt}, 3);
    chk("stream_odd_cnt",  {16'd0, a_odd_cnt}, 3);
    chk("stream_run_len",  {16'd0, a_run_len}, 2);
    a_in_valid = 1'b0;
    tick();
    chk("stream_drained", {31'd0, a_out_valid}, 0);

    // Backpressure: 5 stalls in the output stage, 8 waits.
    drive_a(4'd5); tick();
    a_out_ready = 1'b0;
    drive_a(4'd8);
    #1;
    chk("bp_in_ready_low", {31'd0, a_in_ready}, 0);
    tick(); tick();
    chk("bp_hold_data",  {28'd0, a_out_data}, 5);
    chk("bp_hold_valid", {31'd0, a_out_valid}, 1);
    chk("bp_hold_even_cnt", {16'd0, a_even_cnt}, 3);
    a_out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'd0, a_in_ready}, 1);
    tick();
    a_in_valid = 1'b0;
    chk("bp_second_data", {28'd0, a_out_data}, 8);
    tick();
    chk("bp_even_cnt", {16'd0, a_even_cnt}, 4);
    chk("bp_odd_cnt",  {16'd0, a_odd_cnt}, 4);
    chk("bp_run_len",  {16'd0, a_run_len}, 1);

    // Clear together with an odd accept, then hold the output.
    clear = 1'b1;
    drive_a(4'd9);
    tick();
    clear = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    chk("clracc_even_cnt", {16'd0, a_even_cnt}, 0);
    chk("clracc_odd_cnt",  {16'd0, a_odd_cnt}, 1);
    chk("clracc_run_len",  {16'd0, a_run_len}, 1);
    chk("clracc_out_valid", {31'd0, a_out_valid}, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_out_valid", {31'd0, a_out_valid}, 1);
    chk("clr_out_data",  {28'd0, a_out_data}, 9);
    chk("clr_odd_cnt",   {16'd0, a_odd_cnt}, 0);
    chk("clr_run_len",   {16'd0, a_run_len}, 0);
    a_out_ready = 1'b1;
    tick();
    // Odd after clear starts a new run even though the previous sample was odd.
    drive_a(4'd3); tick();
    a_in_valid = 1'b0;
    chk("postclr_run_len", {16'd0, a_run_len}, 1);
    chk("postclr_odd_cnt", {16'd0, a_odd_cnt}, 1);
    tick();

    // Reset mid-stream drops the in-flight sample.
    drive_a(4'd13); tick();
    a_in_valid = 1'b0;
    chk("midrst_pre_valid", {31'd0, a_out_valid}, 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, a_out_valid}, 0);
    chk("midrst_out_data",  {28'd0, a_out_data}, 0);
    chk("midrst_odd_cnt",   {16'd0, a_odd_cnt}, 0);
    chk("midrst_run_len",   {16'd0, a_run_len}, 0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();

    // Saturation on the 2-bit counters: five even samples.
    for (int i = 1; i <= 5; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'(2 * i);
      tick();
    end
    chk("sat_even_cnt", {30'd0, b_even_cnt}, 3);
    chk("sat_run_len",  {30'd0, b_run_len}, 3);
    chk("sat_odd_cnt",  {30'd0, b_odd_cnt}, 0);
    b_in_data = 8'hA5;
    tick();
    b_in_valid = 1'b0;
    chk("a5_out_data", {24'd0, b_out_data}, 32'hA5);
    chk("a5_out_even", {31'd0, b_out_even}, 0);
    chk("a5_run_len",  {30'd0, b_run_len}, 1);
    chk("a5_even_cnt_held", {30'd0, b_even_cnt}, 3);
`ifdef EVEN_ODD_PARITY_EN
    chk("a5_out_parity", {31'd0, b_out_parity}, 0);
`endif
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
